// File: rtl/mem_pkg.sv
// Shared definitions for the operand/result store of the memory-adder demo.
package mem_pkg;

    localparam int unsigned MEM_SIZE_DEFAULT  = 5;
    localparam int unsigned WORD_SIZE_DEFAULT = 16;
    localparam int unsigned MEM_DEPTH         = 2 ** MEM_SIZE_DEFAULT;

    typedef logic [WORD_SIZE_DEFAULT-1:0] word_t;
    typedef logic [MEM_SIZE_DEFAULT-1:0]  addr_t;

    // Number of words addressable with an address of the given width.
    function automatic int unsigned depth_of(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/mem.sv
// Synchronous RAM with one write port and one registered read port.
// Flop-based storage, cleared by asynchronous reset; write-first on
// same-address collisions.
module mem
    import mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = MEM_SIZE_DEFAULT,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic [MEM_SIZE-1:0]  read_addr,
    input  logic [MEM_SIZE-1:0]  write_addr,
    input  logic [WORD_SIZE-1:0] write_data,
    output logic [WORD_SIZE-1:0] read_data
);

    localparam int unsigned DEPTH = depth_of(MEM_SIZE);

    logic [WORD_SIZE-1:0] store [DEPTH];
    logic [WORD_SIZE-1:0] read_next;

    // Storage array: cleared on reset, written when write_en is sampled high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (write_en) begin
            store[write_addr] <= write_data;
        end
    end

    // Read source: forward the incoming write data when it targets the read address.
    always_comb begin
        read_next = store[read_addr];
        if (write_en && (write_addr == read_addr)) begin
            read_next = write_data;
        end
    end

    // Registered read result; holds its value while read_en is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= read_next;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for mem.
module tb_mem;
    import mem_pkg::*;

    logic  CLK;
    logic  RST;
    logic  read_en;
    logic  write_en;
    addr_t read_addr;
    addr_t write_addr;
    word_t write_data;
    word_t read_data;

    int unsigned total;
    int unsigned passed;

    mem #(
        .MEM_SIZE (MEM_SIZE_DEFAULT),
        .WORD_SIZE(WORD_SIZE_DEFAULT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .read_en   (read_en),
        .write_en  (write_en),
        .read_addr (read_addr),
        .write_addr(write_addr),
        .write_data(write_data),
        .read_data (read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_write(input addr_t a, input word_t d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic do_read(input addr_t a);
        read_en   = 1'b1;
        read_addr = a;
        tick();
        read_en   = 1'b0;
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        RST        = 1'b1;
        read_en    = 1'b0;
        write_en   = 1'b0;
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;

        #12;
        check("rst_init", read_data, 16'h0000);
        RST = 1'b0;
        tick();

        // Populate, then reset asynchronously in the middle of a cycle.
        do_write(5'd7, 16'h7777);
        do_write(5'd31, 16'h1357);
        do_read(5'd7);
        check("pre_rst_rd7", read_data, 16'h7777);
        #3 RST = 1'b1;
        #1 check("rst_async", read_data, 16'h0000);
        #2 RST = 1'b0;
        tick();
        do_read(5'd0);
        check("rst_rd0", read_data, 16'h0000);
        do_read(5'd7);
        check("rst_rd7", read_data, 16'h0000);
        do_read(5'd31);
        check("rst_rd31", read_data, 16'h0000);

        // Basic write then read, then hold with read_en low.
        do_write(5'b00111, 16'hBEEF);
        do_read(5'b00111);
        check("basic_rd", read_data, 16'hBEEF);
        read_addr = 5'd0;
        tick();
        check("hold", read_data, 16'hBEEF);

        // Address boundaries.
        do_write(5'd0, 16'h1234);
        do_write(5'd31, 16'hFFFF);
        do_read(5'd0);
        check("bound_rd0", read_data, 16'h1234);
        do_read(5'd31);
        check("bound_rd31", read_data, 16'hFFFF);
        do_read(5'd1);
        check("bound_rd1", read_data, 16'h0000);

        // Same-address collision: write-first.
        write_en   = 1'b1;
        write_addr = 5'd9;
        write_data = 16'hCAFE;
        read_en    = 1'b1;
        read_addr  = 5'd9;
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("collide", read_data, 16'hCAFE);
        do_read(5'd9);
        check("collide_mem", read_data, 16'hCAFE);

        // Independent ports on different addresses.
        do_write(5'd3, 16'hAAAA);
        write_en   = 1'b1;
        write_addr = 5'd4;
        write_data = 16'h5555;
        read_en    = 1'b1;
        read_addr  = 5'd3;
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("indep_rd3", read_data, 16'hAAAA);
        do_read(5'd4);
        check("indep_rd4", read_data, 16'h5555);

        // Reset during an in-flight write.
        do_write(5'd7, 16'hBEEF);
        write_en   = 1'b1;
        write_addr = 5'd7;
        write_data = 16'h1111;
        #3 RST = 1'b1;
        tick();
        write_en = 1'b0;
        #3 RST = 1'b0;
        tick();
        do_read(5'd7);
        check("midrst_rd7", read_data, 16'h0000);
        do_read(5'd31);
        check("midrst_rd31", read_data, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
